// File: rtl/psram_frame_engine.sv
// Frame engine: streams PSRAM bursts out as video lines, with an optional background fill.
// The fill path is built only when PSRAM_FRAME_FILL_EN is defined.
`timescale 1ns/1ps
module psram_frame_engine #(
    parameter int DQ_WIDTH     = 16,
    parameter int ADDR_WIDTH   = 21,
    parameter int BURST_WORDS  = 32,
    parameter int READ_LATENCY = 16,
    parameter int WRITE_GAP    = 16,
    parameter int H_BURSTS     = 10,
    parameter int V_LINES      = 480,
    parameter int BURST_STEP   = 64,
    parameter int LINE_STRIDE  = 1024
) (
    input  logic                    psram_clock,
    input  logic                    psram_reset,
    input  logic                    init_calib_i,
    input  logic [4*DQ_WIDTH-1:0]   rd_data_i,
    input  logic                    rd_data_valid_i,
    output logic [4*DQ_WIDTH-1:0]   wr_data_o,
    output logic [4*DQ_WIDTH/8-1:0] data_mask_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    cmd_o,
    output logic                    cmd_en_o,
    input  logic                    vsync_i,
    input  logic                    almost_full_i,
    input  logic                    fill_req_i,
    input  logic [31:0]             fill_color_i,
    output logic                    fill_done_o,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic [4*DQ_WIDTH-1:0]   m_axis_tdata,
    output logic                    busy_o,
    output logic                    rd_error_o,
    output logic [7:0]              error_count_o
);
    localparam int BW   = 4 * DQ_WIDTH;
    localparam int M1   = (BURST_WORDS > READ_LATENCY) ? BURST_WORDS : READ_LATENCY;
    localparam int MAXC = (M1 > WRITE_GAP) ? M1 : WRITE_GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int HW   = (H_BURSTS > 1) ? $clog2(H_BURSTS) : 1;
    localparam int VW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    localparam logic [CW-1:0] LAT_END  = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WORD_END = CW'(BURST_WORDS - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(WRITE_GAP - 1);
    localparam logic [HW-1:0] H_END    = HW'(H_BURSTS - 1);
    localparam logic [VW-1:0] V_END    = VW'(V_LINES - 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_VSYNC,
        RD_CMD,
        RD_LAT,
        RD_DATA,
        RD_NEXT
`ifdef PSRAM_FRAME_FILL_EN
        ,
        FILL_CMD,
        FILL_DATA,
        FILL_GAP
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   line_q, line_d;
    logic [HW-1:0]   burst_q, burst_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            vsync_q;
    logic [BW-1:0]   tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            tuser_q, tuser_d;
    logic            tlast_q, tlast_d;
    logic            err_q, err_d;
    logic [7:0]      errcnt_q, errcnt_d;
    logic            vsync_rise;
    logic            last_burst;

    assign vsync_rise = vsync_i & ~vsync_q;
    assign last_burst = (burst_q == H_END) && (line_q == V_END);

`ifdef PSRAM_FRAME_FILL_EN
    logic [31:0] colour_q, colour_d;
`endif

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        tuser_d  = 1'b0;
        tlast_d  = 1'b0;
        err_d    = err_q;
        errcnt_d = errcnt_q;
`ifdef PSRAM_FRAME_FILL_EN
        colour_d = colour_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (init_calib_i) begin
`ifdef PSRAM_FRAME_FILL_EN
                    state_d  = FILL_CMD;
                    colour_d = fill_color_i;
                    line_d   = '0;
                    burst_d  = '0;
                    cnt_d    = '0;
`else
                    state_d  = WAIT_VSYNC;
`endif
                end
            end
            WAIT_VSYNC: begin
`ifdef PSRAM_FRAME_FILL_EN
                if (fill_req_i) begin
                    state_d  = FILL_CMD;
                    colour_d = fill_color_i;
                    line_d   = '0;
                    burst_d  = '0;
                    cnt_d    = '0;
                end else
`endif
                if (vsync_rise) begin
                    state_d = RD_CMD;
                    line_d  = '0;
                    burst_d = '0;
                    cnt_d   = '0;
                end
            end
            RD_CMD: begin
                // The strobe cycle itself counts toward the read latency.
                if (!almost_full_i) begin
                    state_d = RD_LAT;
                    cnt_d   = CW'(1);
                end
            end
            RD_LAT: begin
                if (cnt_q == LAT_END) begin
                    state_d = RD_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_DATA: begin
                tvalid_d = 1'b1;
                tdata_d  = rd_data_i;
                tuser_d  = (line_q == '0) && (burst_q == '0) && (cnt_q == '0);
                tlast_d  = (burst_q == H_END) && (cnt_q == WORD_END);
                if (!rd_data_valid_i) begin
                    err_d = 1'b1;
                    if (errcnt_q != 8'hff) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end
                end
                if (cnt_q == WORD_END) begin
                    state_d = RD_NEXT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_NEXT: begin
                state_d = last_burst ? WAIT_VSYNC : RD_CMD;
                if (burst_q == H_END) begin
                    burst_d = '0;
                    line_d  = (line_q == V_END) ? '0 : line_q + VW'(1);
                end else begin
                    burst_d = burst_q + HW'(1);
                end
            end
`ifdef PSRAM_FRAME_FILL_EN
            FILL_CMD: begin
                state_d = FILL_DATA;
                cnt_d   = '0;
            end
            FILL_DATA: begin
                if (cnt_q == WORD_END) begin
                    state_d = FILL_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FILL_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d = '0;
                    if (last_burst) begin
                        state_d = WAIT_VSYNC;
                        burst_d = '0;
                        line_d  = '0;
                    end else begin
                        state_d = FILL_CMD;
                        if (burst_q == H_END) begin
                            burst_d = '0;
                            line_d  = line_q + VW'(1);
                        end else begin
                            burst_d = burst_q + HW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge psram_clock) begin
        if (psram_reset) begin
            state_q  <= IDLE;
            line_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            vsync_q  <= 1'b1;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            vsync_q  <= vsync_i;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign addr_o = ADDR_WIDTH'(line_q) * ADDR_WIDTH'(LINE_STRIDE)
                  + ADDR_WIDTH'(burst_q) * ADDR_WIDTH'(BURST_STEP);

`ifdef PSRAM_FRAME_FILL_EN
    always_ff @(posedge psram_clock) begin
        if (psram_reset) begin
            colour_q <= '0;
        end else begin
            colour_q <= colour_d;
        end
    end

    assign cmd_o       = (state_q == FILL_CMD);
    assign cmd_en_o    = (state_q == FILL_CMD) ||
                         ((state_q == RD_CMD) && !almost_full_i);
    assign wr_data_o   = (state_q == FILL_DATA) ? BW'({colour_q, colour_q}) : '0;
    assign fill_done_o = (state_q == FILL_GAP) && (cnt_q == GAP_END) && last_burst;
`else
    logic unused_fill;
    assign unused_fill = ^{fill_req_i, fill_color_i};

    assign cmd_o       = 1'b0;
    assign cmd_en_o    = (state_q == RD_CMD) && !almost_full_i;
    assign wr_data_o   = '0;
    assign fill_done_o = 1'b0;
`endif

    assign data_mask_o   = '0;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign busy_o        = (state_q != WAIT_VSYNC) && (state_q != IDLE);
    assign rd_error_o    = err_q;
    assign error_count_o = errcnt_q;
endmodule
